// File: rtl/disparity_pkg.sv
// Shared types and constants for the disparity result readout path.
package disparity_pkg;

  localparam int unsigned DEF_WIDTH         = 250;
  localparam int unsigned DEF_HEIGHT        = 125;
  localparam int unsigned DEF_COORD_W       = 10;
  localparam int unsigned DISP_SCALE_FACTOR = 5;

  // Buffer entry: {eol, sof, data[7:0]}
  localparam int unsigned ENTRY_W = 10;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StScan  = 2'd1,
    StDrain = 2'd2
  } state_e;

endpackage

// File: rtl/disparity_readout_if.sv
// Pixel stream from the readout block to the display/UART path (valid/ready with markers).
interface disparity_readout_if;

  logic [7:0] pix_data;
  logic       pix_valid;
  logic       pix_ready;
  logic       pix_sof;
  logic       pix_eol;

  modport master (
    output pix_data,
    output pix_valid,
    output pix_sof,
    output pix_eol,
    input  pix_ready
  );

  modport slave (
    input  pix_data,
    input  pix_valid,
    input  pix_sof,
    input  pix_eol,
    output pix_ready
  );

endinterface

// File: rtl/readout_skid_fifo.sv
// Two-entry skid FIFO holding captured pixels with their sof/eol sideband.
module readout_skid_fifo
  import disparity_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               flush,
  input  logic               push,
  input  logic [ENTRY_W-1:0] wdata,
  input  logic               pop,
  output logic [ENTRY_W-1:0] rdata,
  output logic               full,
  output logic               empty,
  output logic [1:0]         count
);

  logic [ENTRY_W-1:0] mem_q [2];
  logic               wr_ptr_q, rd_ptr_q;
  logic [1:0]         count_q;
  logic               do_push, do_pop;

  assign full    = (count_q == 2'd2);
  assign empty   = (count_q == 2'd0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  // A push into a full buffer is only taken when the head leaves in the same cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/disparity_readout.sv
// Raster-scans the disparity result memory once the engine is idle and streams pixels out.
// Optional build macro DISP_SCALE_EN: pixels are scaled by 5 and saturated at 255.
module disparity_readout
  import disparity_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned HEIGHT  = DEF_HEIGHT,
  parameter int unsigned COORD_W = DEF_COORD_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               disp_idle,
  output logic [COORD_W-1:0] disp_href,
  output logic [COORD_W-1:0] disp_vref,
  input  logic [7:0]         new_image,
  disparity_readout_if.master pix,
  output logic               busy,
  output logic               frame_done,
  output logic               abort_err
);

  localparam logic [COORD_W-1:0] LastCol = COORD_W'(WIDTH - 1);
  localparam logic [COORD_W-1:0] LastRow = COORD_W'(HEIGHT - 1);

  function automatic logic [7:0] scale_pix(input logic [7:0] v);
`ifdef DISP_SCALE_EN
    logic [10:0] p;
    p = 11'(v) * 11'(DISP_SCALE_FACTOR);
    return (p > 11'd255) ? 8'hff : p[7:0];
`else
    return v;
`endif
  endfunction

  state_e             state_q, state_d;
  logic [COORD_W-1:0] href_q, href_d, vref_q, vref_d;
  logic               inflight_q, sof_q, eol_q;
  logic               frame_done_q, abort_err_q, abort_err_d;
  logic               start_ok, abort, issue, last_addr, drain_done, pop, occ_ok;
  logic               fifo_full, fifo_empty;
  logic [1:0]         fifo_count;
  logic [ENTRY_W-1:0] wdata, rdata;

  assign start_ok  = (state_q == StIdle) && start && disp_idle;
  assign abort     = (state_q != StIdle) && !disp_idle;
  assign last_addr = (href_q == LastCol) && (vref_q == LastRow);
  assign pop       = pix.pix_valid && pix.pix_ready;
  // Room for one more read counts the slot freed by a pop in this same cycle.
  assign occ_ok    = fifo_full ? (pop && !inflight_q)
                               : ((fifo_count == 2'd0) || pop || !inflight_q);
  assign wdata     = {eol_q, sof_q, scale_pix(new_image)};

  readout_skid_fifo u_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .flush  (abort),
    .push   (inflight_q && !abort),
    .wdata  (wdata),
    .pop    (pop),
    .rdata  (rdata),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= StIdle;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_ok) state_d = StScan;
      StScan: begin
        if (abort)                   state_d = StIdle;
        else if (issue && last_addr) state_d = StDrain;
      end
      StDrain: begin
        if (abort || drain_done) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy       = (state_q != StIdle);
    issue      = (state_q == StScan) && disp_idle && occ_ok;
    drain_done = (state_q == StDrain) && disp_idle && (fifo_count == 2'd0) && !inflight_q;
  end

  always_comb begin
    href_d      = href_q;
    vref_d      = vref_q;
    abort_err_d = abort_err_q;
    if (start_ok) begin
      href_d      = '0;
      vref_d      = '0;
      abort_err_d = 1'b0;
    end else if (issue && !last_addr) begin
      if (href_q == LastCol) begin
        href_d = '0;
        vref_d = vref_q + 1'b1;
      end else begin
        href_d = href_q + 1'b1;
      end
    end
    if (abort) abort_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      href_q       <= '0;
      vref_q       <= '0;
      inflight_q   <= 1'b0;
      sof_q        <= 1'b0;
      eol_q        <= 1'b0;
      frame_done_q <= 1'b0;
      abort_err_q  <= 1'b0;
    end else begin
      href_q       <= href_d;
      vref_q       <= vref_d;
      inflight_q   <= issue;
      frame_done_q <= drain_done;
      abort_err_q  <= abort_err_d;
      if (issue) begin
        sof_q <= (href_q == '0) && (vref_q == '0);
        eol_q <= (href_q == LastCol);
      end
    end
  end

  assign disp_href     = href_q;
  assign disp_vref     = vref_q;
  assign frame_done    = frame_done_q;
  assign abort_err     = abort_err_q;
  assign pix.pix_valid = !fifo_empty;
  assign pix.pix_data  = rdata[7:0];
  assign pix.pix_sof   = rdata[8] && !fifo_empty;
  assign pix.pix_eol   = rdata[9] && !fifo_empty;

endmodule

// File: tb/tb_disparity_readout.sv
// Directed bench for disparity_readout on a 4x3 frame with a registered memory model.
module tb_disparity_readout;

  localparam int unsigned W  = 4;
  localparam int unsigned H  = 3;
  localparam int unsigned CW = 10;

  logic          clk;
  logic          reset_n;
  logic          start;
  logic          disp_idle;
  logic [CW-1:0] disp_href, disp_vref;
  logic [7:0]    new_image;
  logic          busy, frame_done, abort_err;

  disparity_readout_if pix ();

  disparity_readout #(
    .WIDTH  (W),
    .HEIGHT (H),
    .COORD_W(CW)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .disp_idle (disp_idle),
    .disp_href (disp_href),
    .disp_vref (disp_vref),
    .new_image (new_image),
    .pix       (pix.master),
    .busy      (busy),
    .frame_done(frame_done),
    .abort_err (abort_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Registered memory: data for an address appears one cycle later.
  int         mem_mode = 0;
  logic [7:0] mem_const = 8'd0;
  initial new_image = 8'd0;
  always @(posedge clk) begin
    if (mem_mode == 0) new_image <= 8'(disp_vref * 4 + disp_href);
    else               new_image <= mem_const;
  end

  typedef struct {
    logic [7:0] d;
    logic       sof;
    logic       eol;
    int         c;
  } rx_t;

  rx_t        rxq[$];
  int         cyc = 0;
  int         fd_cnt = 0;
  bit         stall_chk_en = 1'b0;
  bit         prev_stall = 1'b0;
  logic [9:0] prev_bits = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    rx_t r;
    if (frame_done === 1'b1) fd_cnt++;
    if (stall_chk_en && prev_stall) begin
      check_eq("stall_valid_held", {31'd0, pix.pix_valid}, 32'd1);
      check_eq("stall_bits_held", {22'd0, pix.pix_eol, pix.pix_sof, pix.pix_data},
               {22'd0, prev_bits});
    end
    prev_stall = stall_chk_en && pix.pix_valid && !pix.pix_ready;
    prev_bits  = {pix.pix_eol, pix.pix_sof, pix.pix_data};
    if (pix.pix_valid === 1'b1 && pix.pix_ready === 1'b1) begin
      r.d = pix.pix_data; r.sof = pix.pix_sof; r.eol = pix.pix_eol; r.c = cyc;
      rxq.push_back(r);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(output int start_cyc);
    start = 1'b1;
    tick();
    start_cyc = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int fd0, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (fd_cnt > fd0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check_eq(tag, {31'd0, ok}, 32'd1);
  endtask

  // Checks 12 pixels from rxq[base]: value per mode, sof at 0, eol at every 4th.
  task automatic check_frame(input string tag, input int base, input logic [7:0] cval,
                             input bit use_const);
    check_eq({tag, "_count"}, rxq.size() - base, W * H);
    for (int i = 0; i < W * H && base + i < rxq.size(); i++) begin
      check_eq({tag, "_data"}, {24'd0, rxq[base+i].d}, use_const ? {24'd0, cval} : i);
      check_eq({tag, "_sof"}, {31'd0, rxq[base+i].sof}, (i == 0) ? 1 : 0);
      check_eq({tag, "_eol"}, {31'd0, rxq[base+i].eol}, (i % W == W - 1) ? 1 : 0);
    end
  endtask

  initial begin
    int         sc, base, fd0;
    logic [CW-1:0] h0, v0;
    bit         pat [4];
    logic [7:0] exp49, exp60;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
`ifdef DISP_SCALE_EN
    exp49 = 8'd245;
    exp60 = 8'd255;
`else
    exp49 = 8'd49;
    exp60 = 8'd60;
`endif

    start = 1'b0; disp_idle = 1'b1; pix.pix_ready = 1'b1; reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    check_eq("rst_href", {22'd0, disp_href}, 0);
    check_eq("rst_vref", {22'd0, disp_vref}, 0);
    check_eq("rst_valid", {31'd0, pix.pix_valid}, 0);
    check_eq("rst_sof_eol", {30'd0, pix.pix_sof, pix.pix_eol}, 0);
    check_eq("rst_data", {24'd0, pix.pix_data}, 0);
    check_eq("rst_busy_done_err", {29'd0, busy, frame_done, abort_err}, 0);
    tick(); tick();
    reset_n = 1'b1;
    tick();
    stall_chk_en = 1'b1;

    // Smoke frame, ready always high
    base = rxq.size(); fd0 = fd_cnt;
    pulse_start(sc);
    check_eq("smoke_busy_after_start", {31'd0, busy}, 1);
    wait_done("smoke_done", fd0, 100);
    check_frame("smoke", base, 8'd0, 1'b0);
    if (rxq.size() - base == W * H) begin
      check_eq("smoke_latency_ge2", {31'd0, (rxq[base].c - sc) >= 2}, 1);
      check_eq("smoke_back_to_back", rxq[base+W*H-1].c - rxq[base].c, W * H - 1);
    end
    tick();
    check_eq("smoke_fd_once", fd_cnt - fd0, 1);
    check_eq("smoke_busy_low", {31'd0, busy}, 0);

    // Backpressure: ready pattern 1,0,0,1
    base = rxq.size(); fd0 = fd_cnt;
    pulse_start(sc);
    for (int k = 0; k < 300 && fd_cnt == fd0; k++) begin
      pix.pix_ready = pat[k % 4];
      tick();
    end
    pix.pix_ready = 1'b1;
    check_eq("bp_done", {31'd0, fd_cnt > fd0}, 1);
    check_frame("bp", base, 8'd0, 1'b0);
    tick();
    check_eq("bp_fd_once", fd_cnt - fd0, 1);

    // Start gating: engine not idle
    h0 = disp_href; v0 = disp_vref;
    disp_idle = 1'b0; start = 1'b1;
    tick(); tick(); tick();
    start = 1'b0;
    check_eq("gate_busy", {31'd0, busy}, 0);
    check_eq("gate_href", {22'd0, disp_href}, {22'd0, h0});
    check_eq("gate_vref", {22'd0, disp_vref}, {22'd0, v0});
    disp_idle = 1'b1;
    base = rxq.size(); fd0 = fd_cnt;
    pulse_start(sc);
    tick(); tick();
    pulse_start(sc);
    wait_done("gate_done", fd0, 100);
    for (int i = 0; i < 10; i++) tick();
    check_eq("gate_one_frame", fd_cnt - fd0, 1);
    check_eq("gate_pixels", rxq.size() - base, W * H);
    check_eq("gate_busy_idle", {31'd0, busy}, 0);

    // Abort after 5 transfers
    base = rxq.size(); fd0 = fd_cnt;
    pulse_start(sc);
    for (int i = 0; i < 100 && rxq.size() - base < 5; i++) tick();
    check_eq("abort_got5", {31'd0, rxq.size() - base >= 5}, 1);
    stall_chk_en = 1'b0;
    disp_idle = 1'b0;
    tick();
    check_eq("abort_valid", {31'd0, pix.pix_valid}, 0);
    check_eq("abort_busy", {31'd0, busy}, 0);
    check_eq("abort_err_set", {31'd0, abort_err}, 1);
    for (int i = 0; i < 5 && base + i < rxq.size(); i++)
      check_eq("abort_prefix", {24'd0, rxq[base+i].d}, i);
    disp_idle = 1'b1;
    tick(); tick(); tick();
    check_eq("abort_no_fd", fd_cnt - fd0, 0);
    check_eq("abort_err_sticky", {31'd0, abort_err}, 1);
    stall_chk_en = 1'b1;
    base = rxq.size(); fd0 = fd_cnt;
    pulse_start(sc);
    check_eq("restart_err_clr", {31'd0, abort_err}, 0);
    wait_done("restart_done", fd0, 100);
    check_frame("restart", base, 8'd0, 1'b0);

    // Scaling (or pass-through) of constant memory values
    mem_mode = 1;
    mem_const = 8'd49;
    tick();
    base = rxq.size(); fd0 = fd_cnt;
    pulse_start(sc);
    wait_done("scale49_done", fd0, 100);
    check_frame("scale49", base, exp49, 1'b1);
    mem_const = 8'd60;
    tick();
    base = rxq.size(); fd0 = fd_cnt;
    pulse_start(sc);
    wait_done("scale60_done", fd0, 100);
    check_frame("scale60", base, exp60, 1'b1);
    mem_mode = 0;
    tick();

    // Async reset while draining
    fd0 = fd_cnt;
    pulse_start(sc);
    for (int i = 0; i < 100; i++) begin
      if (disp_href == CW'(W - 1) && disp_vref == CW'(H - 1)) break;
      tick();
    end
    tick();
    pix.pix_ready = 1'b0;
    tick(); tick();
    check_eq("drain_busy", {31'd0, busy}, 1);
    check_eq("drain_valid", {31'd0, pix.pix_valid}, 1);
    stall_chk_en = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check_eq("arst_valid", {31'd0, pix.pix_valid}, 0);
    check_eq("arst_busy", {31'd0, busy}, 0);
    check_eq("arst_addr", {12'd0, disp_vref, disp_href}, 0);
    check_eq("arst_markers", {29'd0, pix.pix_sof, pix.pix_eol, frame_done}, 0);
    check_eq("arst_data_err", {23'd0, pix.pix_data, abort_err}, 0);
    tick();
    reset_n = 1'b1;
    pix.pix_ready = 1'b1;
    tick(); tick(); tick(); tick();
    check_eq("post_rst_valid", {31'd0, pix.pix_valid}, 0);
    check_eq("post_rst_busy", {31'd0, busy}, 0);
    check_eq("post_rst_no_fd", fd_cnt - fd0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/disparity_readout.md
Name: disparity_readout

Overview:
- Reader side of the disparity result memory.
- Once the disparity engine reports idle, the block scans the resultant image in raster order by driving disp_href/disp_vref and capturing new_image one cycle later.
- Pixels stream out on a valid/ready interface with start-of-frame and end-of-line markers, for the display/UART path.
- A 2-entry skid buffer absorbs the one-cycle memory read latency under backpressure.

Parameters:
- WIDTH, 250, output image width in pixels.
- HEIGHT, 125, output image height in rows.
- COORD_W, 10, width of href/vref coordinates.

Ports:
- clk  in  1  single clock for all logic.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request one frame readout; a level or a pulse is accepted.
- disp_idle  in  1  idle flag from the disparity engine; 1 means the result memory is stable.
- disp_href  out  COORD_W  column address to the result memory.
- disp_vref  out  COORD_W  row address to the result memory.
- new_image  in  8  result memory data, valid exactly 1 cycle after the address.
- pix_data  out  8  streamed disparity pixel.
- pix_valid  out  1  pix_data is valid.
- pix_ready  in  1  downstream accepts the pixel.
- pix_sof  out  1  qualifies the first pixel of the frame (0,0).
- pix_eol  out  1  qualifies the last pixel of each row (col WIDTH-1).
- busy  out  1  a frame readout is in progress.
- frame_done  out  1  one-cycle pulse after the last pixel is accepted.
- abort_err  out  1  sticky flag: disp_idle dropped mid-frame.

Behaviour:
- Reset (async, reset_n=0) values:
  - disp_href=0, disp_vref=0, pix_valid=0, pix_sof=0, pix_eol=0, busy=0, frame_done=0, abort_err=0.
  - pix_data=0, skid buffer empty, state IDLE.
  - Deasserting reset mid-frame never resumes a frame.
- States:
  - IDLE -> SCAN when start=1 and disp_idle=1. In the same edge: clear abort_err, set busy, href=vref=0. start with disp_idle=0 is ignored; the block stays in IDLE.
  - SCAN: issue one read per cycle when (buffer occupancy + reads in flight) < 2.
    - Address advances href 0..WIDTH-1, then href=0 and vref+1.
    - Once the read of (WIDTH-1, HEIGHT-1) has issued -> DRAIN. The address holds at the last value.
  - DRAIN: no new reads. When the buffer is empty and no read is in flight -> IDLE. In that transition: frame_done=1 for one cycle, busy=0.
- Latency: first pix_valid no earlier than 2 cycles after the start edge, with pix_ready held high. Steady-state throughput is 1 pixel/cycle with pix_ready=1.
- Handshake:
  - A transfer occurs when pix_valid && pix_ready.
  - pix_data, pix_sof and pix_eol are stable while pix_valid=1 and pix_ready=0. pix_valid never drops without a transfer, except on abort.
  - Captured data is written to the buffer tail; the output is the buffer head.
  - Simultaneous push and pop on a full buffer is legal; occupancy is unchanged.
- Sideband: pix_sof/pix_eol are computed from the coordinate at read issue and stored alongside the data in the buffer.
- Abort: disp_idle=0 while in SCAN or DRAIN means the engine is overwriting the result memory.
  - Next edge: go to IDLE, flush the buffer, pix_valid=0, busy=0, abort_err=1.
  - frame_done is not pulsed.
  - abort_err holds until the next accepted start.
- start while busy=1 is ignored.
- Counters:
  - Unsigned COORD_W arithmetic. No wrap beyond WIDTH-1/HEIGHT-1.
  - Addresses are never driven out of range.

Optional Feature:
- DISP_SCALE_EN defined: pix_data = min(new_image*5, 255), computed in 11-bit arithmetic and then saturated. This expands the 0..49 disparity range to 0..245 for viewing.
- Undefined: pix_data = new_image unchanged.
- The scaling is applied at buffer write; handshake timing is identical in both builds.

Decomposition:
- disparity_pkg:
  - WIDTH/HEIGHT defaults (250/125).
  - COORD_W=10.
  - State encoding constants IDLE/SCAN/DRAIN.
  - DISP_SCALE_FACTOR=5.
- Sub-module readout_skid_fifo: 2-entry, 10-bit-wide (data + sof + eol) FIFO with push/pop/full/empty/count.

Test Plan:
- Full frame, smoke: WIDTH=4, HEIGHT=3, memory returns 4*vref+href, pix_ready=1, start with disp_idle=1 -> 12 pixels 0..11 on consecutive cycles. pix_sof on pixel 0; pix_eol on pixels 3, 7, 11. frame_done pulses once after pixel 11; busy falls.
- Backpressure: same frame, pix_ready toggles 1,0,0,1 repeating -> exactly 12 transfers in order 0..11. No data change while stalled; no read issued while the buffer plus in-flight count is 2.
- Start gating: start=1 with disp_idle=0 -> busy stays 0, no addresses change. Then a second start during SCAN -> ignored, frame count stays 1.
- Abort: disp_idle falls after 5 transfers -> next cycle pix_valid=0, busy=0, abort_err=1, no frame_done. A new start -> abort_err=0 and the frame restarts at (0,0) with pix_sof.
- Async reset mid-DRAIN: reset_n low for 1 cycle -> all outputs at reset values immediately. The buffer is empty after release.
- DISP_SCALE_EN build: memory value 49 -> pix_data 245; 60 -> 255. Without the macro, 49 -> 49.
